// File: rtl/pe_vec_pkg.sv
// pe_vec_pkg: shared FSM state type and fixed-point helpers for the vector PE.
package pe_vec_pkg;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } pe_state_t;

  // Wide enough to carry any accumulator this block can be built with.
  localparam int SAT_W = 64;

  // Accumulator width that cannot overflow over a whole vector.
  function automatic int acc_width(input int n, input int input_num);
    return 2 * n + $clog2(input_num);
  endfunction

  // Drop frac bits (floor toward minus infinity), then clamp to a signed n-bit range.
  function automatic logic signed [SAT_W-1:0] sat_q(input logic signed [SAT_W-1:0] acc,
                                                    input int frac, input int n);
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    shifted = acc >>> frac;
    max_v   = (SAT_W'(1) <<< (n - 1)) - SAT_W'(1);
    min_v   = -max_v - SAT_W'(1);
    if (shifted > max_v)      return max_v;
    else if (shifted < min_v) return min_v;
    else                      return shifted;
  endfunction

endpackage

// File: rtl/pe_vector_lanes_weights.sv
// pe_weight_pingpong: two flop-based weight banks with a loader and a combinational read port.
module pe_weight_pingpong
  import pe_vec_pkg::*;
#(
  parameter int N         = 8,
  parameter int INPUT_NUM = 16,
  parameter int LANES     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic [LANES*N-1:0]           w_data,
  input  logic                         rd_bank,
  input  logic [$clog2(INPUT_NUM)-1:0] rd_k,
  output logic [LANES*N-1:0]           rd_data,
  input  logic                         rel_en,
  output logic [1:0]                   bank_valid
);

  localparam int KW = $clog2(INPUT_NUM);

  logic [LANES*N-1:0] bank [2][INPUT_NUM];
  logic               lb;
  logic [KW-1:0]      wk;
  logic               w_fire;

  assign w_ready = !bank_valid[lb];
  assign w_fire  = w_valid && w_ready;
  assign rd_data = bank[rd_bank][rd_k];

  // Flags and load pointer; a release of the compute bank and a fill of the load bank never hit the same bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_valid <= 2'b00;
      lb         <= 1'b0;
      wk         <= '0;
    end else begin
      if (rel_en) begin
        bank_valid[rd_bank] <= 1'b0;
      end
      if (w_fire) begin
        if (wk == KW'(INPUT_NUM - 1)) begin
          wk             <= '0;
          bank_valid[lb] <= 1'b1;
          lb             <= ~lb;
        end else begin
          wk <= wk + KW'(1);
        end
      end
    end
  end

  // Weight storage is data only; the valid flags alone decide whether it is meaningful.
  always_ff @(posedge clk) begin
    if (w_fire) begin
      bank[lb][wk] <= w_data;
    end
  end

endmodule

// File: rtl/pe_vector_lanes.sv
// pe_vector_lanes: broadcast input stream into LANES MAC lanes with ReLU and saturating quantizer.
module pe_vector_lanes
  import pe_vec_pkg::*;
#(
  parameter int N         = 8,
  parameter int FRAC      = 4,
  parameter int INPUT_NUM = 16,
  parameter int LANES     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [LANES*N-1:0] w_data,
  input  logic               x_valid,
  output logic               x_ready,
  input  logic [N-1:0]       x_data,
  input  logic               relu_en,
  input  logic               reuse,
  output logic               y_valid,
  input  logic               y_ready,
  output logic [LANES*N-1:0] y_data
);

  localparam int ACC_W = acc_width(N, INPUT_NUM);
  localparam int KW    = $clog2(INPUT_NUM);
  localparam int PW    = 2 * N;

  pe_state_t          state;
  logic               cb;
  logic [KW-1:0]      k;
  logic               drain_cnt;
  logic [1:0]         bank_valid;
  logic [LANES*N-1:0] w_col;
  logic [LANES*N-1:0] y_next;
  logic               prod_vld;
  logic               x_fire;
  logic               y_fire;
  logic               rel_en;
  logic               acc_clr;
  logic               out_load;

  assign x_fire   = x_valid && x_ready;
  assign y_fire   = y_valid && y_ready;
  assign rel_en   = y_fire && !reuse;
  assign acc_clr  = ((state == WAIT) && bank_valid[cb]) || (y_fire && reuse);
  assign out_load = (state == DRAIN) && drain_cnt;

  pe_weight_pingpong #(
    .N         (N),
    .INPUT_NUM (INPUT_NUM),
    .LANES     (LANES)
  ) u_banks (
    .clk        (clk),
    .rst        (rst),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_data     (w_data),
    .rd_bank    (cb),
    .rd_k       (k),
    .rd_data    (w_col),
    .rel_en     (rel_en),
    .bank_valid (bank_valid)
  );

  // Compute sequencer: waits for weights, streams a vector, flushes the pipe, then holds the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= WAIT;
      cb        <= 1'b0;
      k         <= '0;
      drain_cnt <= 1'b0;
      x_ready   <= 1'b0;
      y_valid   <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (bank_valid[cb]) begin
            state   <= RUN;
            k       <= '0;
            x_ready <= 1'b1;
          end
        end
        RUN: begin
          if (x_fire) begin
            if (k == KW'(INPUT_NUM - 1)) begin
              state     <= DRAIN;
              k         <= '0;
              x_ready   <= 1'b0;
              drain_cnt <= 1'b0;
            end else begin
              k <= k + KW'(1);
            end
          end
        end
        DRAIN: begin
          drain_cnt <= ~drain_cnt;
          if (drain_cnt) begin
            state   <= OUT;
            y_valid <= 1'b1;
          end
        end
        OUT: begin
          if (y_ready) begin
            y_valid <= 1'b0;
            if (reuse) begin
              state   <= RUN;
              x_ready <= 1'b1;
            end else begin
              state <= WAIT;
              cb    <= ~cb;
            end
          end
        end
        default: state <= WAIT;
      endcase
    end
  end

  // Marks the cycles in which the product registers hold a fresh term to accumulate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prod_vld <= 1'b0;
    else      prod_vld <= x_fire;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [N-1:0]     w_i;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_relu;

    assign w_i = w_col[i*N +: N];

    // Full-precision product of the broadcast input and this lane's weight.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)        prod <= '0;
      else if (x_fire) prod <= $signed({{N{x_data[N-1]}}, x_data}) * $signed({{N{w_i[N-1]}}, w_i});
    end

    // Running dot-product sum, cleared whenever a new vector is about to start.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)          acc <= '0;
      else if (acc_clr)  acc <= '0;
      else if (prod_vld) acc <= acc + $signed({{(ACC_W-PW){prod[PW-1]}}, prod});
    end

    assign acc_relu = (relu_en && acc[ACC_W-1]) ? '0 : acc;
    assign y_next[i*N +: N] = N'(sat_q($signed({{(SAT_W-ACC_W){acc_relu[ACC_W-1]}}, acc_relu}), FRAC, N));
  end

  // Result register captures the quantized lanes on the last drain cycle and holds through backpressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          y_data <= '0;
    else if (out_load) y_data <= y_next;
  end

endmodule

// File: tb/tb_pe_vector_lanes.sv
// tb_pe_vector_lanes: scoreboard bench for the multi-lane PE (N=8, FRAC=4, INPUT_NUM=4, LANES=2).
module tb_pe_vector_lanes;

  localparam int N         = 8;
  localparam int FRAC      = 4;
  localparam int INPUT_NUM = 4;
  localparam int LANES     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_data;
  logic        x_valid;
  logic        x_ready;
  logic [7:0]  x_data;
  logic        relu_en;
  logic        reuse;
  logic        y_valid;
  logic        y_ready;
  logic [15:0] y_data;

  logic [15:0] exp_q [$];
  int          compares   = 0;
  int          mismatches = 0;
  int          hs_count   = 0;

  pe_vector_lanes #(
    .N         (N),
    .FRAC      (FRAC),
    .INPUT_NUM (INPUT_NUM),
    .LANES     (LANES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .w_valid (w_valid),
    .w_ready (w_ready),
    .w_data  (w_data),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .x_data  (x_data),
    .relu_en (relu_en),
    .reuse   (reuse),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y_data  (y_data)
  );

  // Free-running 10-unit clock.
  initial forever #5 clk = ~clk;

  // Hard stop in case the run wedges somewhere unbounded.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compares++;
    if (actual !== expected) begin
      mismatches++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference: per lane signed dot product, optional ReLU, floor shift by FRAC, clamp to 8 bits.
  function automatic logic [15:0] model_y(input logic [15:0] wv [4], input logic [7:0] xs [4], input bit relu);
    logic [15:0] r;
    int          sum;
    int          q;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      sum = 0;
      for (int j = 0; j < INPUT_NUM; j++) begin
        sum += int'($signed(xs[j])) * int'($signed(wv[j][l*8 +: 8]));
      end
      if (relu && sum < 0) sum = 0;
      q = sum >>> FRAC;
      if (q > 127)  q = 127;
      if (q < -128) q = -128;
      r[l*8 +: 8] = q[7:0];
    end
    return r;
  endfunction

  // Every y handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && y_valid && y_ready) begin
      hs_count++;
      if (exp_q.size() == 0) checkOutput("y_unexpected", 32'(exp_q.size()), 32'd1);
      else                   checkOutput("y_data", 32'(y_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic load_weights(input logic [15:0] wv [4], output int stalls);
    int guard;
    stalls = 0;
    for (int j = 0; j < INPUT_NUM; j++) begin
      w_valid = 1'b1;
      w_data  = wv[j];
      guard   = 0;
      @(negedge clk);
      while (!w_ready && guard < 200) begin
        stalls++;
        guard++;
        @(negedge clk);
      end
      if (!w_ready) begin
        checkOutput("w_ready_timeout", 32'(w_ready), 32'd1);
        w_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    w_valid = 1'b0;
  endtask

  task automatic drive_x(input logic [7:0] val, output bit ok);
    int guard;
    ok      = 1'b1;
    guard   = 0;
    x_valid = 1'b1;
    x_data  = val;
    @(negedge clk);
    while (!x_ready && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    if (!x_ready) begin
      checkOutput("x_ready_timeout", 32'(x_ready), 32'd1);
      ok      = 1'b0;
      x_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    x_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] xs [4], input logic [15:0] expv, input string tag);
    bit ok;
    int lat;
    exp_q.push_back(expv);
    for (int j = 0; j < INPUT_NUM; j++) begin
      drive_x(xs[j], ok);
      if (!ok) begin
        void'(exp_q.pop_back());
        return;
      end
    end
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!y_valid && lat < 20);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd3);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] wv [4];
  logic [15:0] wv_b [4];
  logic [7:0]  xv [4];
  logic [7:0]  xv_sat [4];
  int          stalls;
  int          hs0;
  bit          ok;

  initial begin
    rst     = 1'b0;
    w_valid = 1'b0;
    w_data  = '0;
    x_valid = 1'b0;
    x_data  = '0;
    relu_en = 1'b0;
    reuse   = 1'b0;
    y_ready = 1'b1;
    xv      = '{8'h04, 8'h08, 8'h0C, 8'h10};
    xv_sat  = '{8'h7F, 8'h7F, 8'h7F, 8'h7F};

    $display("[TB] reset checks");
    #2;
    checkOutput("rst_w_ready", 32'(w_ready), 32'd1);
    checkOutput("rst_x_ready", 32'(x_ready), 32'd0);
    checkOutput("rst_y_valid", 32'(y_valid), 32'd0);
    checkOutput("rst_y_data", 32'(y_data), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("idle_w_ready", 32'(w_ready), 32'd1);
    checkOutput("idle_x_ready", 32'(x_ready), 32'd0);
    checkOutput("idle_y_valid", 32'(y_valid), 32'd0);
    checkOutput("idle_y_data", 32'(y_data), 32'd0);

    $display("[TB] dot product");
    wv = '{16'h2010, 16'h2010, 16'h2010, 16'h2010};
    load_weights(wv, stalls);
    applyStimulus(xv, 16'h5028, "t2");

    $display("[TB] relu and saturation");
    wv = '{16'h7FF0, 16'h7FF0, 16'h7FF0, 16'h7FF0};
    load_weights(wv, stalls);
    reuse   = 1'b1;
    relu_en = 1'b0;
    applyStimulus(xv, 16'h7FD8, "t3_norelu");
    relu_en = 1'b1;
    applyStimulus(xv, 16'h7F00, "t3_relu");
    relu_en = 1'b0;
    reuse   = 1'b0;
    applyStimulus(xv_sat, 16'h7F80, "t3_sat");

    $display("[TB] ping-pong");
    wv   = '{16'h0810, 16'h0810, 16'h0810, 16'h0810};
    wv_b = '{16'h30E0, 16'h30E0, 16'h30E0, 16'h30E0};
    load_weights(wv, stalls);
    reuse = 1'b0;
    fork
      applyStimulus(xv, 16'h1428, "t4_bank0");
      begin
        int st;
        load_weights(wv_b, st);
        checkOutput("t4_load_stalls", 32'(st), 32'd0);
        @(negedge clk);
        checkOutput("t4_w_ready_full", 32'(w_ready), 32'd0);
      end
    join
    checkOutput("t4_w_ready_freed", 32'(w_ready), 32'd1);
    reuse = 1'b1;
    applyStimulus(xv, 16'h78B0, "t4_bank1");
    load_weights(wv, stalls);
    checkOutput("t4_w_ready_both", 32'(w_ready), 32'd0);
    applyStimulus(xv, 16'h78B0, "t4_reuse");
    checkOutput("t4_w_ready_reuse", 32'(w_ready), 32'd0);
    reuse = 1'b0;
    applyStimulus(xv, 16'h78B0, "t4_release");
    checkOutput("t4_w_ready_back", 32'(w_ready), 32'd1);

    $display("[TB] backpressure");
    y_ready = 1'b0;
    applyStimulus(xv, 16'h1428, "t5");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checkOutput("t5_y_valid_held", 32'(y_valid), 32'd1);
      checkOutput("t5_y_data_held", 32'(y_data), 32'h1428);
      checkOutput("t5_x_ready_low", 32'(x_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    hs0     = hs_count;
    y_ready = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("t5_one_handshake", 32'(hs_count - hs0), 32'd1);
    @(posedge clk);
    #1;

    $display("[TB] reset mid-vector");
    wv = '{16'h2010, 16'h2010, 16'h2010, 16'h2010};
    load_weights(wv, stalls);
    drive_x(8'h04, ok);
    drive_x(8'h08, ok);
    rst = 1'b0;
    #1;
    checkOutput("t6_w_ready", 32'(w_ready), 32'd1);
    checkOutput("t6_x_ready", 32'(x_ready), 32'd0);
    checkOutput("t6_y_valid", 32'(y_valid), 32'd0);
    checkOutput("t6_y_data", 32'(y_data), 32'd0);
    checkOutput("t6_bank_valid", 32'(dut.u_banks.bank_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t6_no_bank_x_ready", 32'(x_ready), 32'd0);
    load_weights(wv, stalls);
    applyStimulus(xv, 16'h5028, "t6_reload");

    $display("[TB] random vectors");
    reuse = 1'b0;
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < INPUT_NUM; j++) begin
        wv[j] = 16'($urandom);
        xv[j] = 8'($urandom);
      end
      relu_en = 1'($urandom_range(0, 1));
      load_weights(wv, stalls);
      applyStimulus(xv, model_y(wv, xv, relu_en), "rand");
    end

    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule

// File: doc/pe_vector_lanes.md
# pe_vector_lanes

Multi-lane successor to the single processing element. One input stream is broadcast to LANES parallel MAC lanes, each with its own weight column. Each lane accumulates INPUT_NUM products, then applies optional ReLU and a saturating fixed-point quantizer. Weights sit in a ping-pong pair of banks, so the next layer's weights load while the current vector computes; all streams use valid/ready handshakes.

## Interface
- N, 8, data/weight width, signed two's complement
- FRAC, 4, fraction bits of inputs, weights and outputs
- INPUT_NUM, 16, products per output (vector length), ≥2
- LANES, 4, parallel output channels, ≥1
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- w_valid  in  1  weight beat valid
- w_ready  out  1  load bank can accept a beat
- w_data  in  LANES*N  weights for index k, lane i at bits [i*N +: N]
- x_valid  in  1  input beat valid
- x_ready  out  1  compute accepts input
- x_data  in  N  input element
- relu_en  in  1  ReLU enable, sampled on the DRAIN→OUT transition
- reuse  in  1  keep the compute bank after output; sampled on the y handshake
- y_valid  out  1  result valid
- y_ready  in  1  consumer accepts result
- y_data  out  LANES*N  quantized lane results, lane i at [i*N +: N]

## Operation
- **Weight banks**
  - Two banks, each INPUT_NUM × LANES*N.
  - Flags bank_valid[1:0]; pointers lb (load bank) and cb (compute bank).
- **Loader**
  - w_ready = !bank_valid[lb].
  - Each handshake writes w_data to bank lb at index wk, then wk++.
  - At wk == INPUT_NUM-1: wk←0, bank_valid[lb]←1, lb←~lb.
- **Compute FSM**
  - WAIT: when bank_valid[cb], go to RUN with k←0 and accumulators cleared.
  - RUN: x_ready=1. Each handshake multiplies x_data by bank[cb][k] per lane, then k++. Handshake at k == INPUT_NUM-1 → DRAIN.
  - DRAIN: 2 cycles for pipeline flush, then OUT.
  - OUT: y_valid=1, y_data held.
    - On the y handshake with reuse=1: go to RUN, clear accumulators.
    - With reuse=0: bank_valid[cb]←0, cb←~cb, go to WAIT.
- **Arithmetic**
  - Product is 2N bits signed, scale 2*FRAC.
  - Accumulator is ACC_W = 2N + $clog2(INPUT_NUM) bits; it never overflows.
  - ReLU forces negative sums to 0 when relu_en=1.
  - Quantize: arithmetic shift right by FRAC (truncate toward −∞), then saturate to [−2^(N−1), 2^(N−1)−1].
- **Boundaries**
  - Load and compute on the same bank cannot coincide: a bank is writable only while !bank_valid.
  - A release and a loader fill in the same cycle are both honored.
  - If both banks are full, w_ready=0.
  - x_valid outside RUN is ignored.
  - Reset mid-operation discards everything: banks invalid, weights must be reloaded.

## Timing
- Reset values: w_ready=1, x_ready=0, y_valid=0, y_data=0, lb=cb=0, bank_valid=0, FSM=WAIT, all counters 0.
- Pipeline: x handshake at edge E0; product register at E0; accumulator at E1; quantized y_data register at E2; y_valid high after E2.
- Latency: last x handshake to y_valid = 3 cycles.
- First x_ready: 1 cycle after bank_valid[cb] rises.
- Throughput: one x per cycle in RUN.
- Minimum gap between vectors: 3 cycles plus the y handshake, plus 1 cycle in WAIT when swapping banks.
- y_valid and y_data are stable until the handshake. Backpressure holds the FSM in OUT with x_ready=0.

## Structure
- Package pe_vec_pkg holds:
  - FSM state enum {WAIT, RUN, DRAIN, OUT}
  - function acc_width(N, INPUT_NUM)
  - saturating quantize function sat_q(acc, FRAC, N)
- Sub-module pe_weight_pingpong: both banks, flags, load pointer/counter and combinational read port (k, cb). It is flop-based, with async clear of the flags only.
- Top level holds the FSM, lane MAC/accumulator generate loop, ReLU and quantizer.

## Test plan
Parameters: N=8, FRAC=4, INPUT_NUM=4, LANES=2.
1. Reset: drive rst=0 → w_ready=1, x_ready=0, y_valid=0, y_data=0. Release rst and idle 10 cycles → nothing changes.
2. Dot product:
   - Weights lane0=0x10 (1.0), lane1=0x20 (2.0) for all k; x=0x04,0x08,0x0C,0x10.
   - Expect y_data lane0=0x28, lane1=0x50.
   - y_valid rises exactly 3 cycles after the 4th x handshake.
3. ReLU and saturation:
   - Lane0 weights 0xF0 with the same x: relu_en=0 → 0xD8; relu_en=1 → 0x00.
   - Lane1 weights 0x7F, x all 0x7F → 0x7F (saturated).
4. Ping-pong:
   - Load bank 0, start the vector, load bank 1 during RUN. w_ready stays 1 until bank 1 is full, then goes 0.
   - reuse=0 → the second vector uses bank 1 weights and w_ready returns to 1.
   - reuse=1 → identical result repeats and w_ready stays 0.
5. Backpressure: hold y_ready=0 for 5 cycles in OUT → y_data constant, x_ready=0, no result lost. Raise y_ready → exactly one handshake.
6. Reset mid-vector: assert rst after 2 x beats → outputs at reset values and bank_valid=0. A new vector requires a full reload and gives the correct result.
